// File: rtl/register_file.sv
// Small register file for the 8-bit datapath: two combinational read ports,
// one clocked write port, and an immediate-load path that always lands in register 0.
module register_file #(
  parameter int numReg   = 2,
  parameter int dataSize = 8
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic [numReg-1:0]   srcA,
  input  logic [numReg-1:0]   srcB,
  input  logic [numReg-1:0]   WriteReg,
  input  logic                RegWriteCtrl,
  input  logic                LoadImm,
  input  logic [dataSize-1:0] WriteData,
  output logic [dataSize-1:0] ReadA,
  output logic [dataSize-1:0] ReadB
);

  localparam int NumEntries = 2 ** numReg;

  // Storage name and indexing are relied on by hierarchical preloads.
  logic [dataSize-1:0] registers   [0:NumEntries-1];
  logic [dataSize-1:0] registers_d [0:NumEntries-1];

  logic              wr_en_s;
  logic [numReg-1:0] wr_addr_s;

  // Write enable and destination select; immediate loads override WriteReg.
  always_comb begin
    wr_en_s = RegWriteCtrl | LoadImm;
    if (LoadImm) begin
      wr_addr_s = {numReg{1'b0}};
    end else begin
      wr_addr_s = WriteReg;
    end
  end

  // Next-state image of the file: at most one entry replaced per cycle.
  always_comb begin
    for (int i = 0; i < NumEntries; i++) begin
      registers_d[i] = registers[i];
    end
    if (wr_en_s) begin
      registers_d[wr_addr_s] = WriteData;
    end else begin
      registers_d[wr_addr_s] = registers[wr_addr_s];
    end
  end

  // State update; reset clears the whole file without waiting for a clock edge.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NumEntries; i++) begin
        registers[i] <= {dataSize{1'b0}};
      end
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        registers[i] <= registers_d[i];
      end
    end
  end

  // No write bypass: reads see the stored value until the edge that updates it.
  assign ReadA = registers[srcA];
  assign ReadB = registers[srcB];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, preload, write,
// write-disable, immediate-load priority, back-to-back writes and async reset.
module tb_register_file;

  logic       CLK;
  logic       Reset_n;
  logic [1:0] srcA;
  logic [1:0] srcB;
  logic [1:0] WriteReg;
  logic       RegWriteCtrl;
  logic       LoadImm;
  logic [7:0] WriteData;
  logic [7:0] ReadA;
  logic [7:0] ReadB;

  int vec_cnt;
  int err_cnt;

  register_file #(.numReg(2), .dataSize(8)) dut (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .srcA         (srcA),
    .srcB         (srcB),
    .WriteReg     (WriteReg),
    .RegWriteCtrl (RegWriteCtrl),
    .LoadImm      (LoadImm),
    .WriteData    (WriteData),
    .ReadA        (ReadA),
    .ReadB        (ReadB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_a(input string name, input logic [7:0] exp);
    vec_cnt++;
    if (ReadA !== exp) begin
      err_cnt++;
      $display("FAIL %s: ReadA=%h expected %h (srcA=%0d) t=%0t", name, ReadA, exp, srcA, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic [7:0] exp);
    vec_cnt++;
    if (ReadB !== exp) begin
      err_cnt++;
      $display("FAIL %s: ReadB=%h expected %h (srcB=%0d) t=%0t", name, ReadB, exp, srcB, $time);
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_v [4];
    exp_v = '{8'h00, 8'h00, 8'h00, 8'h00};
    Reset_n = 1'b0;
    srcA = 2'd2; srcB = 2'd3;
    WriteReg = 2'd2; WriteData = 8'hC3; RegWriteCtrl = 1'b1; LoadImm = 1'b1;
    #1;
    chk_a("reset_a_initial", 8'h00);
    chk_b("reset_b_initial", 8'h00);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      srcA = 2'(i); srcB = 2'(3 - i);
      #1;
      chk_a("reset_a_idx", exp_v[i]);
      chk_b("reset_b_idx", exp_v[3 - i]);
    end
    RegWriteCtrl = 1'b0; LoadImm = 1'b0;
    @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  task automatic test_preload();
    @(negedge CLK);
    dut.registers[3] = 8'd3;
    srcB = 2'd3;
    #1;
    chk_b("preload_comb", 8'd3);
    @(posedge CLK); #1;
    chk_b("preload_hold", 8'd3);
  endtask

  task automatic test_write();
    @(negedge CLK);
    srcA = 2'd2; WriteReg = 2'd2; WriteData = 8'd10; RegWriteCtrl = 1'b1; LoadImm = 1'b0;
    #1;
    chk_a("write_before_edge", 8'd0);
    @(posedge CLK); #1;
    chk_a("write_after_edge", 8'd10);
    RegWriteCtrl = 1'b0;
    srcB = 2'd0; #1; chk_b("write_r0_unchanged", 8'd0);
    srcB = 2'd1; #1; chk_b("write_r1_unchanged", 8'd0);
    srcB = 2'd3; #1; chk_b("write_r3_unchanged", 8'd3);
  endtask

  task automatic test_write_disable();
    @(negedge CLK);
    srcA = 2'd2; WriteReg = 2'd2; WriteData = 8'd1; RegWriteCtrl = 1'b0; LoadImm = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_a("disable_hold", 8'd10);
  endtask

  task automatic test_imm_load();
    @(negedge CLK);
    srcA = 2'd0; srcB = 2'd2;
    WriteReg = 2'd2; WriteData = 8'h55; LoadImm = 1'b1; RegWriteCtrl = 1'b1;
    #1;
    chk_a("imm_before_edge", 8'h00);
    @(posedge CLK); #1;
    chk_a("imm_r0_loaded", 8'h55);
    chk_b("imm_r2_kept", 8'd10);
    LoadImm = 1'b0; RegWriteCtrl = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v [4];
    exp_v = '{8'h0F, 8'hA1, 8'd10, 8'hFF};
    @(negedge CLK);
    WriteReg = 2'd1; WriteData = 8'hA1; RegWriteCtrl = 1'b1; LoadImm = 1'b0;
    @(negedge CLK);
    WriteReg = 2'd3; WriteData = 8'hFF;
    @(negedge CLK);
    WriteReg = 2'd3; WriteData = 8'h0F; RegWriteCtrl = 1'b0; LoadImm = 1'b1;
    @(negedge CLK);
    LoadImm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      srcA = 2'(i); srcB = 2'(i);
      #1;
      chk_a("b2b_a", exp_v[i]);
      chk_b("b2b_same_index", exp_v[i]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    srcA = 2'd1; srcB = 2'd3;
    #1;
    chk_a("async_pre_a", 8'hA1);
    chk_b("async_pre_b", 8'hFF);
    #1;
    Reset_n = 1'b0;
    #1;
    chk_a("async_drop_a", 8'h00);
    chk_b("async_drop_b", 8'h00);
    WriteReg = 2'd1; WriteData = 8'h77; RegWriteCtrl = 1'b1; LoadImm = 1'b0;
    @(posedge CLK); #1;
    chk_a("async_write_ignored", 8'h00);
    @(negedge CLK);
    RegWriteCtrl = 1'b0;
    Reset_n = 1'b1;
    #1;
    chk_a("async_release_zero", 8'h00);
    WriteReg = 2'd1; WriteData = 8'h5A; RegWriteCtrl = 1'b1;
    @(posedge CLK); #1;
    chk_a("async_first_write", 8'h5A);
    chk_b("async_r3_cleared", 8'h00);
    RegWriteCtrl = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_preload();
    test_write();
    test_write_disable();
    test_imm_load();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Small general-purpose register file for the 8-bit datapath.
- Two asynchronous (combinational) read ports, A/rs and B/rt.
- One synchronous write port, plus an immediate-load path that always targets register 0.
- Sits between instruction decode (register indices) and the ALU/writeback stage.

Parameters:
- numReg, 2: register address width in bits; the file holds 2**numReg registers (default 4).
- dataSize, 8: width of each register and of all data ports, in bits.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset; clears every register.
- srcA  input  numReg  read-port A register index (rs).
- srcB  input  numReg  read-port B register index (rt).
- WriteReg  input  numReg  destination register index for normal writes.
- RegWriteCtrl  input  1  normal write enable.
- LoadImm  input  1  immediate-load enable; destination is forced to register 0.
- WriteData  input  dataSize  data to write (register result or immediate).
- ReadA  output  dataSize  contents of registers[srcA].
- ReadB  output  dataSize  contents of registers[srcB].

Interface rule (already decided): one clock (CLK); reset is asynchronous and active-low (Reset_n).

Behaviour:
- Storage:
  - Array named `registers`, 2**numReg entries of dataSize bits, index 0 to 2**numReg-1.
  - Benches preload entries hierarchically (dut.registers[i]), so the array name and indexing are fixed.
- Reset:
  - Reset_n low forces all registers to 0 immediately, without waiting for a clock edge.
  - ReadA and ReadB therefore read 0 while Reset_n is low.
  - Writes are ignored while Reset_n is low.
  - Release is synchronous to normal operation; the first write can occur on the first rising edge with Reset_n high.
- Read:
  - ReadA = registers[srcA] and ReadB = registers[srcB], purely combinational, zero latency.
  - Outputs follow index changes in the same delta, with no clock needed.
  - srcA == srcB is legal; both ports return the same value.
- Write, on the rising edge of CLK with Reset_n high:
  - Write enable = RegWriteCtrl OR LoadImm.
  - Destination = 0 if LoadImm = 1, else WriteReg.
  - LoadImm takes priority over WriteReg when both enables are high.
  - If enable = 0, no register changes, whatever WriteReg/WriteData are.
  - Exactly one register is written per cycle; all others hold.
- Read-during-write: no bypass.
  - A read of the register being written returns the old value until the rising edge.
  - It returns WriteData after the edge.
- Width: all indices are full-range, so no out-of-range case exists; data is written unmodified (no extension/truncation).
- X-handling: if an enable is X at a clock edge, the register file contents are undefined for that cycle. Benches must drive all control inputs to known values after reset.

Test Plan:
- Reset: Reset_n=0 with CLK running, srcA=2, srcB=3 -> ReadA=0, ReadB=0 immediately and for all indices 0..3.
- Preload/read: after reset release, set dut.registers[3]=8'd3 hierarchically, srcB=3 -> ReadB=3 combinationally with no clock edge.
- Write: srcA=2, WriteReg=2, WriteData=10, RegWriteCtrl=1, LoadImm=0 -> ReadA=0 before the edge, ReadA=10 after the next rising edge; registers 0, 1, 3 unchanged.
- Write-disable: WriteReg=2, WriteData=1, RegWriteCtrl=0, LoadImm=0 for two edges -> ReadA stays 10.
- Immediate load: WriteReg=2, WriteData=8'h55, LoadImm=1, RegWriteCtrl=1 -> after the edge registers[0]=0x55 and registers[2] still 10; srcA=0 -> ReadA=0x55.
- Async reset mid-operation: registers hold non-zero values, pulse Reset_n low between clock edges -> ReadA and ReadB drop to 0 immediately. An enabled write presented while Reset_n is low has no effect.
